// File: rtl/spi_xfer_pkg.sv
// Shared types and constants for the byte-wide SPI master shift engine.
package spi_xfer_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic {OWN_Z80, OWN_DMA} owner_t;

  localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;
  localparam logic [3:0] LAST_PHASE    = 4'd15;

endpackage

// File: rtl/spi_xfer_phase_timer.sv
// Half-period divider and 16-step phase counter for one SPI byte.
module spi_phase_timer
  import spi_xfer_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             phase_end,
  output logic [3:0]       phase,
  output logic             last
);

  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] div_cnt;

  assign phase_end = run && (div_cnt == '0);
  assign last      = (phase == LAST_PHASE);

  // The divisor is captured on start so mid-transfer changes wait for the next byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_lat <= '0;
      div_cnt <= '0;
      phase   <= '0;
    end else if (start) begin
      div_lat <= div;
      div_cnt <= div;
      phase   <= '0;
    end else if (run) begin
      if (div_cnt == '0) begin
        div_cnt <= div_lat;
        if (!last)
          phase <= phase + 4'd1;
      end else begin
        div_cnt <= div_cnt - DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_xfer.sv
// SPI mode-0 MSB-first byte exchange engine shared by the Z80 data port and DMA channel.
module spi_xfer
  import spi_xfer_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             zwr_stb,
  input  logic             zrd_stb,
  input  logic [7:0]       zdata,
  output logic [7:0]       zrd_data,
  output logic             busy,
  input  logic             dma_req,
  input  logic [7:0]       dma_wrdata,
  output logic             dma_stb,
  output logic [7:0]       dma_rddata,
  output logic             sck,
  output logic             mosi,
  input  logic             miso
);

  state_t     state;
  state_t     state_nx;
  owner_t     owner;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;
  logic       accept;
  logic       phase_end;
  logic [3:0] phase;
  logic       last;

  assign accept = (state == IDLE) && (zwr_stb || zrd_stb || dma_req);

  spi_phase_timer #(.DIV_W(DIV_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept),
    .run       (state == SHIFT),
    .div       (cfg_div),
    .phase_end (phase_end),
    .phase     (phase),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT:   if (phase_end && last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Receive byte is complete after phase 14, so it is published on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sh      <= SPI_IDLE_BYTE;
      rx_sh      <= '0;
      owner      <= OWN_Z80;
      zrd_data   <= SPI_IDLE_BYTE;
      dma_rddata <= '0;
    end else if (accept) begin
      if (zwr_stb) begin
        tx_sh <= zdata;
        owner <= OWN_Z80;
      end else if (zrd_stb) begin
        tx_sh <= SPI_IDLE_BYTE;
        owner <= OWN_Z80;
      end else begin
        tx_sh <= dma_wrdata;
        owner <= OWN_DMA;
      end
    end else if (state == SHIFT && phase_end) begin
      if (!phase[0]) begin
        rx_sh <= {rx_sh[6:0], miso};
      end else if (!last) begin
        tx_sh <= {tx_sh[6:0], 1'b1};
      end else if (owner == OWN_DMA) begin
        dma_rddata <= rx_sh;
      end else begin
        zrd_data <= rx_sh;
      end
    end
  end

  always_comb begin
    sck     = 1'b0;
    mosi    = 1'b1;
    dma_stb = 1'b0;
    busy    = (state != IDLE);
    case (state)
      SHIFT: begin
        sck  = phase[0];
        mosi = tx_sh[7];
      end
      DONE:    dma_stb = (owner == OWN_DMA);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_xfer.sv
// Directed self-checking bench for spi_xfer: DMA/Z80 transfers, priority, reset abort, divider change.
module tb_spi_xfer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cfg_div;
  logic       zwr_stb, zrd_stb;
  logic [7:0] zdata;
  logic [7:0] zrd_data;
  logic       busy;
  logic       dma_req;
  logic [7:0] dma_wrdata;
  logic       dma_stb;
  logic [7:0] dma_rddata;
  logic       sck, mosi, miso;

  logic       loop;
  logic [7:0] slave_byte;

  int total = 0;
  int bad   = 0;

  int          cyc = 0;
  int          start_cyc = 0;
  int          sck_cnt = 0;
  int          xfer_n = 0;
  int          stb_n = 0;
  int          stb_cyc [16];
  int          stb_rel [16];
  logic [7:0]  stb_data [16];
  logic [31:0] mosi_hist = '0;
  logic        busy_q = 1'b0;
  logic        sck_q = 1'b0;

  spi_xfer #(.DIV_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_div    (cfg_div),
    .zwr_stb    (zwr_stb),
    .zrd_stb    (zrd_stb),
    .zdata      (zdata),
    .zrd_data   (zrd_data),
    .busy       (busy),
    .dma_req    (dma_req),
    .dma_wrdata (dma_wrdata),
    .dma_stb    (dma_stb),
    .dma_rddata (dma_rddata),
    .sck        (sck),
    .mosi       (mosi),
    .miso       (miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Slave shifts its byte MSB first, advancing after every sck rising edge.
  always_comb begin
    logic [2:0] idx;
    idx  = 3'(7 - sck_cnt);
    miso = loop ? mosi : slave_byte[idx];
  end

  always @(negedge clk) begin
    if (busy && !busy_q) begin
      start_cyc = cyc;
      sck_cnt   = 0;
      xfer_n++;
    end
    if (sck && !sck_q) begin
      sck_cnt++;
      mosi_hist = {mosi_hist[30:0], mosi};
    end
    if (dma_stb && stb_n < 16) begin
      stb_cyc[stb_n]  = cyc;
      stb_rel[stb_n]  = cyc - start_cyc;
      stb_data[stb_n] = dma_rddata;
      stb_n++;
    end
    busy_q = busy;
    sck_q  = sck;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_stb(input string tag);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (dma_stb) break;
    end
    chk(tag, 32'(dma_stb), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    int x0;
    rst_n = 1'b0; cfg_div = '0; zwr_stb = 1'b0; zrd_stb = 1'b0; zdata = '0;
    dma_req = 1'b0; dma_wrdata = '0; loop = 1'b1; slave_byte = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stb", 32'(dma_stb), 32'd0);
    chk("rst_dma_rddata", 32'(dma_rddata), 32'h00);
    chk("rst_zrd_data", 32'(zrd_data), 32'hFF);
    rst_n = 1'b1;

    // DMA byte A5, D=0, loopback
    @(posedge clk); #1;
    cfg_div = 8'd0; dma_wrdata = 8'hA5; dma_req = 1'b1; loop = 1'b1; base = stb_n;
    wait_stb("t1_stb_seen");
    dma_req = 1'b0;
    wait_idle("t1_idle");
    repeat (5) @(negedge clk);
    chk("t1_mosi_bits", 32'(mosi_hist[7:0]), 32'hA5);
    chk("t1_sck_pulses", 32'(sck_cnt), 32'd8);
    chk("t1_stb_cycle", 32'(stb_rel[base]), 32'd16);
    chk("t1_stb_count", 32'(stb_n - base), 32'd1);
    chk("t1_dma_rddata", 32'(dma_rddata), 32'hA5);
    chk("t1_zrd_hold", 32'(zrd_data), 32'hFF);

    // Z80 read, D=1, slave sends 3C
    @(posedge clk); #1;
    cfg_div = 8'd1; loop = 1'b0; slave_byte = 8'h3C; base = stb_n; zrd_stb = 1'b1;
    @(posedge clk); #1;
    zrd_stb = 1'b0;
    wait_idle("t2_idle");
    repeat (3) @(negedge clk);
    chk("t2_mosi_ff", 32'(mosi_hist[7:0]), 32'hFF);
    chk("t2_zrd_data", 32'(zrd_data), 32'h3C);
    chk("t2_no_stb", 32'(stb_n - base), 32'd0);
    chk("t2_dma_hold", 32'(dma_rddata), 32'hA5);
    chk("t2_sck_pulses", 32'(sck_cnt), 32'd8);

    // Back-to-back DMA, D=2
    @(posedge clk); #1;
    cfg_div = 8'd2; loop = 1'b1; dma_wrdata = 8'h12; dma_req = 1'b1; base = stb_n;
    wait_stb("t3_stb0_seen");
    dma_wrdata = 8'h34;
    wait_stb("t3_stb1_seen");
    dma_req = 1'b0;
    wait_idle("t3_idle");
    repeat (5) @(negedge clk);
    chk("t3_stb_count", 32'(stb_n - base), 32'd2);
    chk("t3_stb0_cycle", 32'(stb_rel[base]), 32'd48);
    chk("t3_stb_spacing", 32'(stb_cyc[base+1] - stb_cyc[base]), 32'd50);
    chk("t3_data0", 32'(stb_data[base]), 32'h12);
    chk("t3_data1", 32'(stb_data[base+1]), 32'h34);
    chk("t3_mosi_bits", 32'(mosi_hist[15:0]), 32'h1234);

    // Z80 write and DMA request together; second Z80 write while busy is dropped
    @(posedge clk); #1;
    cfg_div = 8'd0; zdata = 8'h55; zwr_stb = 1'b1; dma_wrdata = 8'h0F; dma_req = 1'b1;
    x0 = xfer_n; base = stb_n;
    @(posedge clk); #1;
    zwr_stb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    zdata = 8'h99; zwr_stb = 1'b1;
    @(posedge clk); #1;
    zwr_stb = 1'b0;
    wait_stb("t4_stb_seen");
    dma_req = 1'b0;
    wait_idle("t4_idle");
    repeat (40) @(negedge clk);
    chk("t4_xfer_count", 32'(xfer_n - x0), 32'd2);
    chk("t4_mosi_order", 32'(mosi_hist[15:0]), 32'h550F);
    chk("t4_zrd_data", 32'(zrd_data), 32'h55);
    chk("t4_dma_data", 32'(stb_data[base]), 32'h0F);
    chk("t4_stb_count", 32'(stb_n - base), 32'd1);
    chk("t4_idle", 32'(busy), 32'd0);

    // Reset asserted during phase 7
    @(posedge clk); #1;
    cfg_div = 8'd0; dma_wrdata = 8'h77; dma_req = 1'b1; base = stb_n;
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1;
    chk("t5_ph7_sck", 32'(sck), 32'd1);
    chk("t5_ph7_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; dma_req = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_sck", 32'(sck), 32'd0);
    chk("t5_rst_mosi", 32'(mosi), 32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_stb", 32'(dma_stb), 32'd0);
    chk("t5_rst_dma_rddata", 32'(dma_rddata), 32'h00);
    chk("t5_rst_zrd_data", 32'(zrd_data), 32'hFF);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t5_no_stb", 32'(stb_n - base), 32'd0);
    dma_wrdata = 8'hC3; dma_req = 1'b1;
    wait_stb("t5_stb_seen");
    dma_req = 1'b0;
    wait_idle("t5_idle");
    chk("t5_dma_rddata", 32'(dma_rddata), 32'hC3);
    chk("t5_stb_cycle", 32'(stb_rel[base]), 32'd16);
    chk("t5_mosi_bits", 32'(mosi_hist[7:0]), 32'hC3);

    // Divider changed 1 -> 5 during the first of two DMA bytes
    @(posedge clk); #1;
    cfg_div = 8'd1; dma_wrdata = 8'h81; dma_req = 1'b1; base = stb_n;
    repeat (6) @(posedge clk);
    #1;
    cfg_div = 8'd5;
    wait_stb("t6_stb0_seen");
    dma_wrdata = 8'h7E;
    wait_stb("t6_stb1_seen");
    dma_req = 1'b0;
    wait_idle("t6_idle");
    chk("t6_stb0_cycle", 32'(stb_rel[base]), 32'd32);
    chk("t6_stb1_cycle", 32'(stb_rel[base+1]), 32'd96);
    chk("t6_stb_spacing", 32'(stb_cyc[base+1] - stb_cyc[base]), 32'd98);
    chk("t6_data0", 32'(stb_data[base]), 32'h81);
    chk("t6_data1", 32'(stb_data[base+1]), 32'h7E);
    chk("t6_mosi_bits", 32'(mosi_hist[15:0]), 32'h817E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_xfer.md
# spi_xfer

Byte-wide SPI master shift engine. It answers the DMA engine's SPI device channel (`req` level, `stb` pulse per byte) and the Z80 SPI data port. Each transfer is one 8-bit full-duplex exchange in SPI mode 0, MSB first. It sits between the DMA/port decode logic and the SD-card pins; chip-select is driven elsewhere.

## Interface
Parameters:
- `DIV_W`, default 8: width of the half-period divider.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_div`  in  DIV_W  SCK half-period = `cfg_div`+1 clk cycles. Latched at transfer start.
- `zwr_stb`  in  1  Z80 write to SPI data port; transmit `zdata`.
- `zrd_stb`  in  1  Z80 read of SPI data port; transmit 8'hFF.
- `zdata`  in  8  Z80 write data.
- `zrd_data`  out  8  last byte received by a Z80-initiated transfer.
- `busy`  out  1  transfer in progress.
- `dma_req`  in  1  DMA byte request, level.
- `dma_wrdata`  in  8  byte to send on DMA transfers (8'hFF on DMA read cycles, supplied by DMA).
- `dma_stb`  out  1  one-cycle pulse: DMA byte done, `dma_rddata` valid.
- `dma_rddata`  out  8  last byte received by a DMA-initiated transfer.
- `sck`  out  1  SPI clock, idle low.
- `mosi`  out  1  SPI data out, idle high.
- `miso`  in  1  SPI data in.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: a request is accepted in priority order `zwr_stb` > `zrd_stb` > `dma_req`. On acceptance:
  - load the shift register with `zdata`, 8'hFF or `dma_wrdata`;
  - latch the owner (Z80/DMA) and `cfg_div`;
  - zero the phase counter;
  - go to SHIFT.
- Z80 strobes arriving in SHIFT/DONE are dropped. `dma_req` is only sampled in IDLE and is not latched.
- SHIFT: 16 half-phases k=0..15, each lasting `cfg_div`+1 cycles.
  - `sck` = k[0].
  - `mosi` = shift register bit 7.
  - At the end of each even phase (the SCK rising edge), shift `miso` into the receive register LSB.
  - At the end of each odd phase except 15, shift the transmit register left by one.
  - The end of phase 15 goes to DONE.
- DONE (one cycle):
  - `sck`=0, `mosi`=1;
  - copy the receive byte to `zrd_data` (Z80 owner) or `dma_rddata` (DMA owner);
  - if the owner is DMA, `dma_stb`=1;
  - go to IDLE.
- Only the owning side's read register updates. The other side's register holds its value.
- Divider counter is DIV_W bits and counts down from the latched value. Phase counter is 4 bits, with no wrap beyond 15.
- `busy` = state != IDLE.

## Timing
- Reset values: `sck`=0, `mosi`=1, `busy`=0, `dma_stb`=0, `dma_rddata`=8'h00, `zrd_data`=8'hFF, state IDLE.
- Acceptance edge = T0. SHIFT occupies cycles 1..16(D+1), where D = latched `cfg_div`. DONE/`dma_stb` falls on cycle 16(D+1)+1. With D=0 that is cycle 17.
- `mosi` carries bit 7 from cycle 1. There are exactly 8 `sck` high pulses per byte.
- Back-to-back DMA with `dma_req` held: the next acceptance is in the IDLE cycle after DONE. The byte period is 16(D+1)+2 cycles.
- The DMA updates `dma_req` on the `dma_stb` edge, so the engine sees the new level in that IDLE cycle.
- `cfg_div` changes mid-transfer affect only the next transfer.
- `rst_n` low in any state: on the next edge, all outputs take their reset values and the transfer is aborted with no `dma_stb`.

## Structure
- Shared package `spi_xfer_pkg`:
  - state enum {IDLE, SHIFT, DONE};
  - `SPI_IDLE_BYTE` = 8'hFF;
  - owner enum {OWN_Z80, OWN_DMA}.
- One natural sub-module: `spi_phase_timer`. It holds the divider counter and phase counter, loads on start, and outputs `phase_end`, `phase[3:0]`, `last`.

## Test plan
- D=0, `dma_req`=1 with `dma_wrdata`=8'hA5, `miso` looped to `mosi`, `dma_req` dropped after the first strobe -> `mosi` bits 1,0,1,0,0,1,0,1; 8 `sck` pulses; `dma_stb` exactly on cycle 17; `dma_rddata`=8'hA5; `zrd_data` stays 8'hFF.
- `zrd_stb`, D=1, slave drives 8'h3C on `miso` -> `mosi` constant 1; `zrd_data`=8'h3C; no `dma_stb`.
- D=2, `dma_req` held for two bytes 8'h12 then 8'h34 -> two `dma_stb` pulses 50 cycles apart; the transmitted bytes match in order.
- `zwr_stb` (8'h55) and `dma_req` in the same IDLE cycle -> the Z80 byte goes first and the DMA byte follows. A second `zwr_stb` issued while `busy` is ignored (no third transfer).
- `rst_n` low during phase 7 -> next cycle `sck`=0, `mosi`=1, `busy`=0, no `dma_stb`. After release, a fresh 8'hC3 DMA byte completes correctly.
- `cfg_div` changed 1->5 mid-transfer -> the current byte keeps 2-cycle half-periods; the next byte uses 6-cycle half-periods.
